command_sequencer: RTL and testbench



---
 rtl/command_sequencer.sv | 175 +++++++++++++++++
 tb/tb_command_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_sequencer.sv
// command_sequencer: decodes UART command frames into register-file/ALU strobes
// and returns read data or a multi-word ALU result over a valid/ready handshake.
module command_sequencer #(
    parameter int DATA_WIDTH          = 8,
    parameter int REGISTER_FILE_DEPTH = 16,
    parameter int ALU_RESULT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES      = 1024,
    parameter int OPERAND_A_ADDR      = 0,
    parameter int OPERAND_B_ADDR      = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   rx_valid,
    input  logic [DATA_WIDTH-1:0]                  rx_data,
    input  logic                                   rf_read_data_valid,
    input  logic [DATA_WIDTH-1:0]                  rf_read_data,
    input  logic                                   alu_result_valid,
    input  logic [ALU_RESULT_WIDTH-1:0]            alu_result,
    input  logic                                   tx_ready,
    output logic                                   tx_valid,
    output logic [DATA_WIDTH-1:0]                  tx_data,
    output logic [$clog2(REGISTER_FILE_DEPTH)-1:0] rf_address,
    output logic                                   rf_write_en,
    output logic [DATA_WIDTH-1:0]                  rf_write_data,
    output logic                                   rf_read_en,
    output logic [3:0]                             alu_function,
    output logic                                   alu_en,
    output logic                                   alu_clk_en,
    output logic                                   busy,
    output logic                                   frame_error
);
    localparam int AW = $clog2(REGISTER_FILE_DEPTH);
    localparam int RESULT_WORDS = ALU_RESULT_WIDTH / DATA_WIDTH;
    localparam int CW = $clog2(RESULT_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUNC, ALU_WAIT, TX_SEND
    } state_t;

    state_t                      state_q, state_d;
    logic [TW-1:0]               tmr_q, tmr_d;
    logic [AW-1:0]               addr_q, addr_d;
    logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
    logic [3:0]                  func_q, func_d;
    logic                        wr_q, wr_d, rd_q, rd_d, alu_q, alu_d, err_q, err_d;
    logic [ALU_RESULT_WIDTH-1:0] buf_q, buf_d;
    logic [CW-1:0]               rem_q, rem_d;
    logic                        bad_addr, counting, capture, timed_out;

    assign bad_addr  = 32'(rx_data) >= REGISTER_FILE_DEPTH;
    assign counting  = state_q != IDLE && state_q != TX_SEND;
    assign capture   = (state_q == RD_WAIT && rf_read_data_valid) ||
                       (state_q == ALU_WAIT && alu_result_valid);
    assign timed_out = counting && !rx_valid && !capture && tmr_q == TW'(TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        func_d  = func_q;
        buf_d   = buf_q;
        rem_d   = rem_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        alu_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (rx_valid) begin
                if (rx_data == DATA_WIDTH'('hAA)) state_d = WR_ADDR;
                else if (rx_data == DATA_WIDTH'('hBB)) state_d = RD_ADDR;
                else if (rx_data == DATA_WIDTH'('hCC)) state_d = OP_A;
                else if (rx_data == DATA_WIDTH'('hDD)) state_d = ALU_FUNC;
                else err_d = 1'b1;
            end
            WR_ADDR, RD_ADDR: if (rx_valid) begin
                if (bad_addr) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    addr_d  = rx_data[AW-1:0];
                    rd_d    = state_q == RD_ADDR;
                    state_d = state_q == RD_ADDR ? RD_WAIT : WR_DATA;
                end
            end
            WR_DATA: if (rx_valid) begin
                wdata_d = rx_data;
                wr_d    = 1'b1;
                state_d = IDLE;
            end
            OP_A, OP_B: if (rx_valid) begin
                addr_d  = state_q == OP_A ? AW'(OPERAND_A_ADDR) : AW'(OPERAND_B_ADDR);
                wdata_d = rx_data;
                wr_d    = 1'b1;
                state_d = state_q == OP_A ? OP_B : ALU_FUNC;
            end
            ALU_FUNC: if (rx_valid) begin
                func_d  = rx_data[3:0];
                alu_d   = 1'b1;
                state_d = ALU_WAIT;
            end
            RD_WAIT: begin
                err_d = rx_valid;
                if (rf_read_data_valid) begin
                    buf_d   = ALU_RESULT_WIDTH'(rf_read_data);
                    rem_d   = CW'(1);
                    state_d = TX_SEND;
                end
            end
            ALU_WAIT: begin
                err_d = rx_valid;
                if (alu_result_valid) begin
                    buf_d   = alu_result;
                    rem_d   = CW'(RESULT_WORDS);
                    state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                err_d = rx_valid;
                if (tx_ready) begin
                    // Shifting keeps the outgoing word at the bottom of the buffer.
                    buf_d   = buf_q >> DATA_WIDTH;
                    rem_d   = rem_q - CW'(1);
                    state_d = rem_q == CW'(1) ? IDLE : TX_SEND;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timed_out) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
        tmr_d = (state_d != state_q || rx_valid) ? '0 : counting ? tmr_q + TW'(1) : tmr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            func_q  <= '0;
            buf_q   <= '0;
            rem_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            alu_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            func_q  <= func_d;
            buf_q   <= buf_d;
            rem_q   <= rem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            alu_q   <= alu_d;
            err_q   <= err_d;
        end
    end

    assign tx_valid      = state_q == TX_SEND;
    assign tx_data       = buf_q[DATA_WIDTH-1:0];
    assign rf_address    = addr_q;
    assign rf_write_en   = wr_q;
    assign rf_write_data = wdata_q;
    assign rf_read_en    = rd_q;
    assign alu_function  = func_q;
    assign alu_en        = alu_q;
    assign alu_clk_en    = state_q == ALU_FUNC || state_q == ALU_WAIT;
    assign busy          = state_q != IDLE;
    assign frame_error   = err_q;
endmodule

// File: tb/tb_command_sequencer.sv
// tb_command_sequencer: randomized frames against a frame-level model, with a
// scoreboard monitor checking strobes, transmitted words and error pulses.
module tb_command_sequencer;
    localparam int DW = 8, DEPTH = 16, RWID = 16, TO = 32;

    logic clk = 1'b0, reset = 1'b1;
    logic rx_valid = 1'b0, rf_read_data_valid = 1'b0, alu_result_valid = 1'b0, tx_ready = 1'b0;
    logic [DW-1:0] rx_data = '0, rf_read_data = '0, tx_data, rf_write_data;
    logic [RWID-1:0] alu_result = '0;
    logic [3:0] rf_address, alu_function;
    logic tx_valid, rf_write_en, rf_read_en, alu_en, alu_clk_en, busy, frame_error;

    always #5 clk = ~clk;

    command_sequencer #(
        .DATA_WIDTH(DW), .REGISTER_FILE_DEPTH(DEPTH), .ALU_RESULT_WIDTH(RWID),
        .TIMEOUT_CYCLES(TO), .OPERAND_A_ADDR(0), .OPERAND_B_ADDR(1)
    ) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rf_read_data_valid(rf_read_data_valid), .rf_read_data(rf_read_data),
        .alu_result_valid(alu_result_valid), .alu_result(alu_result), .tx_ready(tx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .rf_address(rf_address),
        .rf_write_en(rf_write_en), .rf_write_data(rf_write_data), .rf_read_en(rf_read_en),
        .alu_function(alu_function), .alu_en(alu_en), .alu_clk_en(alu_clk_en),
        .busy(busy), .frame_error(frame_error)
    );

    typedef struct packed {logic [3:0] a; logic [7:0] d;} wr_t;
    int n_chk = 0, n_fail = 0, exp_err = 0, rd_delay = 0;
    logic hold_lo = 1'b0;
    logic [7:0] mregs [16];
    logic [7:0] shadow [16];
    wr_t exp_wr [$];
    logic [3:0] exp_rd [$];
    logic [3:0] exp_alu [$];
    logic [7:0] exp_tx [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [31:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected event with value %0h, none required", nm, act);
    endtask

    // Behaviour of the external ALU; shared by the ALU emulator and the model.
    function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        return (f[0] ? 16'(a) * 16'(b) : 16'(a) + 16'(b)) ^ {f, 12'h000};
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) begin
            mregs[i] = '0;
            shadow[i] = '0;
        end
    end

    always @(negedge clk) if (!reset && rf_write_en) shadow[rf_address] = rf_write_data;

    initial forever begin
        logic [3:0] a;
        int d;
        @(negedge clk);
        if (!reset && rf_read_en) begin
            a = rf_address;
            d = rd_delay != 0 ? rd_delay : int'($urandom_range(1, 4));
            repeat (d) @(posedge clk);
            #1 rf_read_data = shadow[a];
            rf_read_data_valid = 1'b1;
            @(posedge clk);
            #1 rf_read_data_valid = 1'b0;
        end
    end

    initial forever begin
        int d;
        @(negedge clk);
        if (!reset && alu_en) begin
            alu_result = alu_ref(alu_function, shadow[0], shadow[1]);
            d = int'($urandom_range(1, 5));
            repeat (d) @(posedge clk);
            #1 alu_result_valid = 1'b1;
            @(posedge clk);
            #1 alu_result_valid = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1 tx_ready = hold_lo ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    initial begin
        logic prev_stall;
        logic [7:0] prev_data;
        wr_t w;
        prev_stall = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (frame_error) begin
                    if (exp_err > 0) begin
                        n_chk++;
                        exp_err--;
                    end else unexpected("frame_error", 1);
                end
                if (rf_write_en) begin
                    if (exp_wr.size() == 0) unexpected("rf_write", {rf_address, rf_write_data});
                    else begin
                        w = exp_wr.pop_front();
                        check("rf_write addr/data", {rf_address, rf_write_data}, {w.a, w.d});
                    end
                end
                if (rf_read_en) begin
                    if (exp_rd.size() == 0) unexpected("rf_read", rf_address);
                    else check("rf_read addr", rf_address, exp_rd.pop_front());
                end
                if (alu_en) begin
                    if (exp_alu.size() == 0) unexpected("alu_en", alu_function);
                    else check("alu_en func/clk_en", {alu_clk_en, alu_function}, {1'b1, exp_alu.pop_front()});
                end
                if (prev_stall && tx_valid) check("tx_data held", tx_data, prev_data);
                if (tx_valid && tx_ready) begin
                    if (exp_tx.size() == 0) unexpected("tx word", tx_data);
                    else check("tx word", tx_data, exp_tx.pop_front());
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data = tx_data;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1 rx_valid = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3)) @(posedge clk);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 300) begin
            @(posedge clk);
            #1 k++;
        end
        check("return to idle", busy, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_tx();
        int k = 0;
        while (!tx_valid && k < 50) begin
            @(posedge clk);
            #1 k++;
        end
        check("tx_valid rise", tx_valid, 1);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        send(8'hAA);
        gap();
        if (a >= DEPTH) begin
            exp_err++;
            send(a);
            return;
        end
        send(a);
        gap();
        exp_wr.push_back({a[3:0], d});
        mregs[a[3:0]] = d;
        send(d);
    endtask

    task automatic do_read(input logic [7:0] a);
        send(8'hBB);
        gap();
        if (a >= DEPTH) exp_err++;
        else begin
            exp_rd.push_back(a[3:0]);
            exp_tx.push_back(mregs[a[3:0]]);
        end
        send(a);
    endtask

    task automatic do_alu(input logic ops, input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
        logic [15:0] r;
        if (ops) begin
            send(8'hCC);
            gap();
            exp_wr.push_back({4'd0, a});
            mregs[0] = a;
            send(a);
            gap();
            exp_wr.push_back({4'd1, b});
            mregs[1] = b;
            send(b);
        end else send(8'hDD);
        gap();
        r = alu_ref(f[3:0], mregs[0], mregs[1]);
        exp_alu.push_back(f[3:0]);
        exp_tx.push_back(r[7:0]);
        exp_tx.push_back(r[15:8]);
        send(f);
    endtask

    task automatic do_junk(input logic [7:0] w);
        exp_err++;
        send(w);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] w;
        #2;
        check("reset outputs", {tx_valid, busy, rf_write_en, rf_read_en, alu_en, alu_clk_en, frame_error}, 0);
        check("reset tx_data/addr/func", {tx_data, rf_address, alu_function, rf_write_data}, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        do_write(8'h05, 8'h3C);
        check("write addr/data held", {rf_address, rf_write_data}, {4'd5, 8'h3C});
        wait_idle();

        do_write(8'h07, 8'h5A);
        wait_idle();
        hold_lo = 1'b1;
        rd_delay = 3;
        do_read(8'h07);
        wait_tx();
        for (int i = 0; i < 4; i++) begin
            check("stalled tx word", {tx_valid, tx_data}, {1'b1, 8'h5A});
            @(posedge clk);
            #1;
        end
        hold_lo = 1'b0;
        rd_delay = 0;
        wait_idle();

        do_alu(1'b1, 8'h12, 8'h34, 8'h02);
        while (!tx_valid && busy) begin
            check("alu_clk_en in wait", alu_clk_en, 1);
            @(posedge clk);
            #1;
        end
        check("alu_clk_en after result", alu_clk_en, 0);
        wait_idle();

        do_read(8'h10);
        check("bad address busy", busy, 0);
        wait_idle();
        do_junk(8'h55);
        check("junk word busy", busy, 0);
        wait_idle();

        exp_err++;
        send(8'hAA);
        send(8'h03);
        repeat (TO - 2) @(posedge clk);
        #1 check("busy before timeout", busy, 1);
        @(posedge clk);
        #1 check("busy at last count", busy, 1);
        @(posedge clk);
        #1 check("idle after timeout", busy, 0);
        repeat (2) @(posedge clk);
        do_write(8'h03, 8'hA5);
        wait_idle();

        hold_lo = 1'b1;
        do_read(8'h03);
        wait_tx();
        exp_err++;
        send(8'h77);
        check("tx held across rx", {tx_valid, tx_data}, {1'b1, 8'hA5});
        hold_lo = 1'b0;
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: do_write(8'($urandom_range(0, 19)), 8'($urandom));
                1: do_read(8'($urandom_range(0, 19)));
                2: do_alu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
                3: do_alu(1'b0, 8'h00, 8'h00, 8'($urandom));
                default: begin
                    w = 8'($urandom);
                    while (w == 8'hAA || w == 8'hBB || w == 8'hCC || w == 8'hDD) w = 8'($urandom);
                    do_junk(w);
                end
            endcase
            wait_idle();
        end

        hold_lo = 1'b1;
        do_read(8'h05);
        wait_tx();
        reset = 1'b1;
        #1 check("reset mid-transmit", {tx_valid, busy}, 0);
        exp_tx.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        hold_lo = 1'b0;
        do_write(8'h09, 8'h81);
        wait_idle();

        repeat (10) @(posedge clk);
        #1;
        check("pending writes", exp_wr.size(), 0);
        check("pending reads", exp_rd.size(), 0);
        check("pending alu", exp_alu.size(), 0);
        check("pending tx", exp_tx.size(), 0);
        check("pending frame_error", exp_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
